sp_bram_arbiter: RTL and testbench
==================================

Name: sp_bram_arbiter

Overview:
Shares the single-port sp-RAM (S/E/B matrix store) between three requesters: the matrix memory controller (port 0), the host loader (port 1) and the host result readback (port 2). It grants at most one beat per cycle, using round-robin with bounded bursts. A priority lock lets the systolic compute phase own the RAM outright. It also returns read data with per-requester valid tags, which compensates for the fixed BRAM read latency.

Parameters:
AW, 32, address width
DW, 64, data width
MAX_BURST, 8, maximum consecutive beats one requester may hold while others wait (>=1)
RD_LAT, 1, BRAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  3  per-requester access request; bit i = requester i
wen  in  3  per-requester write enable (valid with req)
addr  in  3*AW  per-requester address; slice i = requester i
wdata  in  3*DW  per-requester write data
prio_lock  in  1  requester 0 has absolute priority while high (driven from systolic-active state)
gnt  out  3  one-hot grant; beat transferred when gnt[i]&req[i]
rvalid  out  3  read data valid for requester i
rdata  out  DW  broadcast read data (= bram_rdata)
bram_en  out  1  RAM enable
bram_wen  out  1  RAM write enable
bram_addr  out  AW  RAM address
bram_wdata  out  DW  RAM write data
bram_rdata  in  DW  RAM read data
busy  out  1  a read is in flight in the latency pipe or a grant is active

Behaviour:
- Reset (async, rst_n low): gnt=0, rvalid=0, bram_en=0, bram_wen=0, bram_addr=0, bram_wdata=0, busy=0. RR pointer=0, owner_valid=0, beat_cnt=0, read pipe cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced afterwards. Requesters must reissue.
- gnt is combinational from req and state; zero-cycle arbitration latency. At most one gnt bit is high. gnt[i] is never high without req[i].
- Winner selection, in priority order:
  1. prio_lock&req[0] -> requester 0. This preempts the current owner at the cycle boundary.
  2. owner_valid & req[owner] & beat_cnt<MAX_BURST -> owner continues.
  3. Otherwise, round-robin: the first requesting index starting at ptr, wrapping 2->0.
- Update on a granted beat:
  - New winner: owner<=winner, owner_valid<=1, beat_cnt<=1, ptr<=(winner+1) mod 3.
  - Continuing owner: beat_cnt<=beat_cnt+1.
  - prio_lock winner: beat_cnt is held at 1, so lock grants never exhaust the burst.
- No req: owner_valid<=0 and ptr is unchanged.
- Burst exhausted (beat_cnt==MAX_BURST) with no other requester: the owner is re-granted as a new winner (beat_cnt<=1). There is no bubble cycle.
- RAM drive:
  - bram_en = |gnt.
  - bram_wen = wen[winner] & bram_en.
  - bram_addr and bram_wdata mux the winner's slice, and are 0 when there is no grant.
- Reads: a granted beat with wen=0 pushes {1,winner} into an RD_LAT-deep shift pipe. rvalid[id] is high for exactly 1 cycle, RD_LAT cycles after the grant; rdata=bram_rdata in that cycle. Writes push {0,x}.
- Back-to-back reads from different requesters return in grant order, one per cycle.
- busy = |gnt | any valid entry in the read pipe.
- Simultaneous prio_lock rise and an owner mid-burst: requester 0 takes the grant that cycle, and the old owner's burst is abandoned (owner_valid follows the new winner).

Test Plan:
- Reset then single requester 1 writes: req=3'b010, wen=3'b010, addr1=0x15000, wdata=0xA5A5 for 4 cycles -> gnt=3'b010 each cycle, bram_wen=1, bram_addr=0x15000; after release bram_en=0.
- All three requesting reads continuously with MAX_BURST=2 -> grant sequence 0,0,1,1,2,2,0,0; rvalid[i] follows each grant by RD_LAT=1 cycle with matching rdata.
- prio_lock asserted while requester 2 is at beat 1 of a burst, req=3'b101 -> gnt switches to 3'b001 the same cycle and stays while lock is high (20 cycles); requester 2 is granted the cycle after lock and req[0] drop.
- RD_LAT=3, interleaved reads 1,2,1 on consecutive cycles -> rvalid=010,100,010 on cycles +3,+4,+5; busy stays high until the last rvalid.
- Single requester 0 holds req for 10 cycles with MAX_BURST=8 and no contention -> continuous grant with no gap.
- Assert rst_n low with a read in flight (RD_LAT=2) -> all outputs 0 immediately, and no rvalid after reset release.

Source files
------------

// File: rtl/sp_bram_arbiter.sv
// Single-port BRAM arbiter: three requesters, round-robin with bounded bursts,
// a priority lock for requester 0, and read-return tagging across the RAM read latency.
`timescale 1ns/1ps
module sp_bram_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        wen,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   wdata,
  input  logic              prio_lock,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DW-1:0]     rdata,
  output logic              bram_en,
  output logic              bram_wen,
  output logic [AW-1:0]     bram_addr,
  output logic [DW-1:0]     bram_wdata,
  input  logic [DW-1:0]     bram_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic          owner_valid;
  logic [CW-1:0] beat_cnt;

  logic [1:0]    win;
  logic          win_valid;
  logic          cont_win;
  logic [1:0]    rr1, rr2;
  logic          sel_wen;

  logic [RD_LAT-1:0]       pv;
  logic [RD_LAT-1:0][1:0]  pid;
  logic [RD_LAT:0]         pv_sh;
  logic [RD_LAT:0][1:0]    pid_sh;

  assign rr1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign rr2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;

  // Lock winner is handled as a fresh winner, which keeps beat_cnt pinned at 1.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cont_win  = 1'b0;
    if (prio_lock && req[0]) begin
      win       = 2'd0;
      win_valid = 1'b1;
    end else if (owner_valid && req[owner] && (beat_cnt < CW'(MAX_BURST))) begin
      win       = owner;
      win_valid = 1'b1;
      cont_win  = 1'b1;
    end else if (req[ptr]) begin
      win       = ptr;
      win_valid = 1'b1;
    end else if (req[rr1]) begin
      win       = rr1;
      win_valid = 1'b1;
    end else if (req[rr2]) begin
      win       = rr2;
      win_valid = 1'b1;
    end
    if (!rst_n) begin
      win_valid = 1'b0;
      cont_win  = 1'b0;
    end
  end

  always_comb begin
    bram_addr  = '0;
    bram_wdata = '0;
    sel_wen    = 1'b0;
    if (win_valid) begin
      case (win)
        2'd0: begin
          bram_addr  = addr[AW-1:0];
          bram_wdata = wdata[DW-1:0];
          sel_wen    = wen[0];
        end
        2'd1: begin
          bram_addr  = addr[2*AW-1:AW];
          bram_wdata = wdata[2*DW-1:DW];
          sel_wen    = wen[1];
        end
        default: begin
          bram_addr  = addr[3*AW-1:2*AW];
          bram_wdata = wdata[3*DW-1:2*DW];
          sel_wen    = wen[2];
        end
      endcase
    end
  end

  assign gnt      = win_valid ? (3'b001 << win) : 3'b000;
  assign bram_en  = win_valid;
  assign bram_wen = win_valid & sel_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      beat_cnt    <= '0;
    end else if (win_valid) begin
      if (cont_win) begin
        beat_cnt <= beat_cnt + CW'(1);
      end else begin
        owner       <= win;
        owner_valid <= 1'b1;
        beat_cnt    <= CW'(1);
        ptr         <= (win == 2'd2) ? 2'd0 : win + 2'd1;
      end
    end else begin
      owner_valid <= 1'b0;
    end
  end

  // Shift through a widened vector so RD_LAT=1 needs no special case.
  assign pv_sh  = {pv, win_valid & ~sel_wen};
  assign pid_sh = {pid, win};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv  <= '0;
      pid <= '0;
    end else begin
      pv  <= pv_sh[RD_LAT-1:0];
      pid <= pid_sh[RD_LAT-1:0];
    end
  end

  assign rvalid = pv[RD_LAT-1] ? (3'b001 << pid[RD_LAT-1]) : 3'b000;
  assign rdata  = bram_rdata;
  assign busy   = win_valid | (|pv);

endmodule

// File: tb/tb_sp_bram_arbiter.sv
// Bench for sp_bram_arbiter: three parameterisations share stimulus; a vector
// table plus hand-written sequences, with a read-return scoreboard.
`timescale 1ns/1ps
module tb_sp_bram_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      req = '0;
  logic [2:0]      wen = '0;
  logic            prio_lock = 1'b0;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [DW-1:0]   bram_rdata;
  int unsigned     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  assign bram_rdata = {32'hCAFEF00D, cyc};
  assign addr  = {32'h0000_2000, 32'h0001_5000, 32'h0000_1000};
  assign wdata = {64'h3333, 64'hA5A5, 64'h1111};

  logic [2:0]    gnt_o  [3];
  logic [2:0]    rv_o   [3];
  logic [DW-1:0] rd_o   [3];
  logic          en_o   [3];
  logic          bwen_o [3];
  logic [AW-1:0] baddr_o[3];
  logic [DW-1:0] bwd_o  [3];
  logic          busy_o [3];

  sp_bram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(2), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .prio_lock(prio_lock), .gnt(gnt_o[0]), .rvalid(rv_o[0]), .rdata(rd_o[0]),
    .bram_en(en_o[0]), .bram_wen(bwen_o[0]), .bram_addr(baddr_o[0]),
    .bram_wdata(bwd_o[0]), .bram_rdata(bram_rdata), .busy(busy_o[0]));

  sp_bram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .prio_lock(prio_lock), .gnt(gnt_o[1]), .rvalid(rv_o[1]), .rdata(rd_o[1]),
    .bram_en(en_o[1]), .bram_wen(bwen_o[1]), .bram_addr(baddr_o[1]),
    .bram_wdata(bwd_o[1]), .bram_rdata(bram_rdata), .busy(busy_o[1]));

  sp_bram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8), .RD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .prio_lock(prio_lock), .gnt(gnt_o[2]), .rvalid(rv_o[2]), .rdata(rd_o[2]),
    .bram_en(en_o[2]), .bram_wen(bwen_o[2]), .bram_addr(baddr_o[2]),
    .bram_wdata(bwd_o[2]), .bram_rdata(bram_rdata), .busy(busy_o[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard of expected read returns per instance
  typedef struct {
    int          inst;
    int unsigned due;
    logic [2:0]  rv;
  } sb_t;
  sb_t q[$];
  logic [2:0] mon = '0;

  function automatic int unsigned lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  task automatic sb_push(input int i, input logic [2:0] g, input logic [2:0] w);
    if ((g != 3'b000) && ((g & w) == 3'b000)) q.push_back('{i, cyc + lat(i), g});
  endtask

  task automatic sb_check(input int i);
    logic [2:0] e;
    e = '0;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].inst == i) begin
        if (q[k].due == cyc) begin
          e = q[k].rv;
          q.delete(k);
        end
        break;
      end
    end
    chk($sformatf("rvalid[%0d]", i), rv_o[i], e);
    if (e != 3'b000) chk($sformatf("rdata[%0d]", i), rd_o[i], {32'hCAFEF00D, cyc});
  endtask

  function automatic int pending(input int i);
    int n = 0;
    foreach (q[k]) if (q[k].inst == i) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mon[0]) sb_check(0);
      if (mon[1]) sb_check(1);
      if (mon[2]) sb_check(2);
    end
  end

  function automatic logic [AW-1:0] exp_addr(input logic [2:0] g);
    case (g)
      3'b001:  return 32'h0000_1000;
      3'b010:  return 32'h0001_5000;
      3'b100:  return 32'h0000_2000;
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic l);
    @(posedge clk);
    #1;
    req = r; wen = w; prio_lock = l;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req = '0; wen = '0; prio_lock = 1'b0;
    rst_n = 1'b0;
    mon = '0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_gnt"},   gnt_o[i],   '0);
    chk({tag, "_rv"},    rv_o[i],    '0);
    chk({tag, "_en"},    en_o[i],    '0);
    chk({tag, "_wen"},   bwen_o[i],  '0);
    chk({tag, "_addr"},  baddr_o[i], '0);
    chk({tag, "_wdata"}, bwd_o[i],   '0);
    chk({tag, "_busy"},  busy_o[i],  '0);
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] rq;
    logic [2:0] w;
    logic       l;
    logic [2:0] g;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit r, input logic [2:0] rq, input logic [2:0] w,
                      input logic l, input logic [2:0] g);
    tbl.push_back('{r, rq, w, l, g});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #2;
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");
    chk_zero(2, "rst_c");

    // Single requester 1 writes, MAX_BURST=8 instance
    do_reset();
    mon = 3'b010;
    for (int n = 0; n < 4; n++) begin
      drive(3'b010, 3'b010, 1'b0);
      chk("wr_gnt", gnt_o[1], 3'b010);
      chk("wr_wen", bwen_o[1], 1'b1);
      chk("wr_addr", baddr_o[1], 32'h0001_5000);
      chk("wr_wdata", bwd_o[1], 64'hA5A5);
    end
    drive(3'b000, 3'b000, 1'b0);
    chk("wr_rel_en", en_o[1], 1'b0);
    chk("wr_rel_addr", baddr_o[1], '0);

    // Table: burst round-robin then priority lock, MAX_BURST=2 / RD_LAT=1 instance
    addv(1, 3'b111, 3'b000, 0, 3'b001);
    addv(0, 3'b111, 3'b000, 0, 3'b001);
    addv(0, 3'b111, 3'b000, 0, 3'b010);
    addv(0, 3'b111, 3'b000, 0, 3'b010);
    addv(0, 3'b111, 3'b000, 0, 3'b100);
    addv(0, 3'b111, 3'b000, 0, 3'b100);
    addv(0, 3'b111, 3'b000, 0, 3'b001);
    addv(0, 3'b111, 3'b000, 0, 3'b001);
    addv(0, 3'b000, 3'b000, 0, 3'b000);
    addv(1, 3'b100, 3'b000, 0, 3'b100);
    for (int n = 0; n < 20; n++) addv(0, 3'b101, 3'b000, 1, 3'b001);
    addv(0, 3'b100, 3'b000, 0, 3'b100);
    addv(0, 3'b000, 3'b000, 0, 3'b000);
    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset();
        mon = 3'b001;
      end
      drive(tbl[k].rq, tbl[k].w, tbl[k].l);
      chk($sformatf("tbl%0d_gnt", k), gnt_o[0], tbl[k].g);
      chk($sformatf("tbl%0d_en", k), en_o[0], |tbl[k].g);
      chk($sformatf("tbl%0d_addr", k), baddr_o[0], exp_addr(tbl[k].g));
      sb_push(0, tbl[k].g, tbl[k].w);
    end
    drive(3'b000, 3'b000, 1'b0);
    chk("tbl_drain", pending(0), 0);

    // RD_LAT=3 interleaved reads 1,2,1; busy held until the last return
    do_reset();
    mon = 3'b010;
    drive(3'b010, 3'b000, 1'b0); chk("lat3_g0", gnt_o[1], 3'b010); sb_push(1, 3'b010, 3'b000);
    drive(3'b100, 3'b000, 1'b0); chk("lat3_g1", gnt_o[1], 3'b100); sb_push(1, 3'b100, 3'b000);
    drive(3'b010, 3'b000, 1'b0); chk("lat3_g2", gnt_o[1], 3'b010); sb_push(1, 3'b010, 3'b000);
    for (int n = 0; n < 3; n++) begin
      drive(3'b000, 3'b000, 1'b0);
      chk($sformatf("lat3_busy%0d", n), busy_o[1], 1'b1);
    end
    drive(3'b000, 3'b000, 1'b0);
    chk("lat3_idle_busy", busy_o[1], 1'b0);
    chk("lat3_drain", pending(1), 0);

    // Requester 0 alone for 10 beats: burst limit re-grants without a gap
    do_reset();
    mon = 3'b010;
    for (int n = 0; n < 10; n++) begin
      drive(3'b001, 3'b000, 1'b0);
      chk($sformatf("solo%0d_gnt", n), gnt_o[1], 3'b001);
      sb_push(1, 3'b001, 3'b000);
    end
    for (int n = 0; n < 4; n++) drive(3'b000, 3'b000, 1'b0);
    chk("solo_drain", pending(1), 0);

    // Reset with a read in flight (RD_LAT=2): outputs clear, nothing returns
    do_reset();
    mon = 3'b100;
    drive(3'b010, 3'b000, 1'b0);
    chk("rstmid_gnt", gnt_o[2], 3'b010);
    @(posedge clk);
    #1;
    req = '0;
    chk("rstmid_busy", busy_o[2], 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero(2, "rstmid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(3'b000, 3'b000, 1'b0);
      chk($sformatf("rstmid_norv%0d", n), rv_o[2], 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
